fifo_uart_tx: RTL and testbench

Read-side consumer for the team's FIFO: drains words from the FIFO's `empty`/`r_data`/`rd` port and sends each word as an asynchronous serial frame on a single line. The frame is 1 start bit, B data bits LSB first, and STOP_BITS stop bits. The block sits between the FIFO output and the board's serial TX pin. Bit timing comes from an internal clock divider, not an external baud tick.

---
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a FIFO read port. Each popped word goes out as
// one frame: a start bit, B data bits LSB first, then STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int B            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_en,
  input  logic         empty,
  input  logic [B-1:0] r_data,
  output logic         rd,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done_tick
);

  localparam int BC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int N_W  = $clog2(B) + 1;

  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(CLKS_PER_BIT - 1);
  localparam logic [N_W-1:0]  N_LAST    = N_W'(B - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [N_W-1:0]    n_q, n_d;
  logic              stop_q, stop_d;
  logic [B-1:0]      sh_q, sh_d;
  logic              tx_q, tx_d;

  logic              bc_wrap;
  logic [B-1:0]      sh_shifted;

  assign bc_wrap    = (bc_q == BC_LAST);
  assign sh_shifted = sh_q >> 1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    bc_d         = bc_q;
    n_d          = n_q;
    stop_d       = stop_q;
    sh_d         = sh_q;
    tx_d         = tx_q;
    rd           = 1'b0;
    tx_done_tick = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The pop is Mealy so the FIFO advances on the same edge we capture.
        rd = tx_en & ~empty & ~reset;
        if (rd) begin
          sh_d    = r_data;
          bc_d    = '0;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d = 1'b1;
        end
      end

      START: begin
        if (bc_wrap) begin
          bc_d    = '0;
          n_d     = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          bc_d = bc_q + BC_W'(1);
        end
      end

      DATA: begin
        if (bc_wrap) begin
          bc_d = '0;
          if (n_q == N_LAST) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            sh_d = sh_shifted;
            n_d  = n_q + N_W'(1);
            tx_d = sh_shifted[0];
          end
        end else begin
          bc_d = bc_q + BC_W'(1);
        end
      end

      STOP: begin
        if (bc_wrap) begin
          bc_d = '0;
          if (stop_q == STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          bc_d = bc_q + BC_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only, and the
    // shift register is cleared on reset like every other register here.
    if (reset) begin
      state_q <= IDLE;
      bc_q    <= '0;
      n_q     <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      n_q     <= n_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two configurations run side by side from one FIFO
// write stream, each checked cycle by cycle against a frame-timing model.
module tb_fifo_uart_tx;

  localparam int B    = 8;
  localparam int NCFG = 2;

  logic         clk;
  logic         reset;
  logic         tx_en;
  logic         wr;
  logic [B-1:0] w_data;
  int           cyc;
  bit           chk_en;

  int n_checks;
  int n_pass;

  function automatic int flen(input int g);
    return (g == 0) ? (1 + B + 1) * 16 : (1 + B + 2) * 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int C  = (g == 0) ? 16 : 4;
    localparam int SB = (g == 0) ? 1 : 2;
    localparam int F  = (1 + B + SB) * C;

    logic         empty, rd, tx, tx_busy, tx_done_tick;
    logic [B-1:0] r_data;
    logic [B-1:0] mem [8];
    logic [2:0]   wp = '0;
    logic [2:0]   rp = '0;
    int           count = 0;

    int rd_n = 0;
    int done_n = 0;
    int last_gap = 0;
    int last_pop = 0;

    bit           in_frame = 1'b0;
    int           p = 0;
    logic [B-1:0] word = '0;
    logic         e_tx, e_busy, e_done, e_rd;
    int           k;

    assign empty  = (count == 0);
    assign r_data = mem[rp];

    fifo_uart_tx #(.B(B), .CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_en        (tx_en),
      .empty        (empty),
      .r_data       (r_data),
      .rd           (rd),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick)
    );

    // Behavioural FIFO with depth 8 (W=3): pointer wrap exercised by the bench.
    always @(posedge clk) begin
      if (wr) begin
        mem[wp] <= w_data;
        wp      <= wp + 3'd1;
      end
      if (rd && count != 0) rp <= rp + 3'd1;
      count <= count + (wr ? 1 : 0) - ((rd && count != 0) ? 1 : 0);
    end

    // Frame model: a frame popped in cycle p occupies cycles p+1 .. p+F;
    // bit slot (cycle-p-1)/C is start, data bits LSB first, then stop bits.
    always @(negedge clk) begin
      if (chk_en) begin
        if (in_frame && cyc > p + F) in_frame = 1'b0;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0;
        if (in_frame) begin
          k      = cyc - p - 1;
          e_busy = 1'b1;
          e_done = (cyc == p + F);
          if (k / C == 0) e_tx = 1'b0;
          else if (k / C <= B) e_tx = word[k / C - 1];
        end else begin
          e_rd = tx_en && !empty && !reset;
        end
        check($sformatf("cfg%0d_rd@%0d", g, cyc), rd, e_rd);
        check($sformatf("cfg%0d_tx@%0d", g, cyc), tx, e_tx);
        check($sformatf("cfg%0d_busy@%0d", g, cyc), tx_busy, e_busy);
        check($sformatf("cfg%0d_done@%0d", g, cyc), tx_done_tick, e_done);
        if (rd) begin
          rd_n++;
          last_gap = cyc - last_pop;
          last_pop = cyc;
        end
        if (tx_done_tick) done_n++;
        if (reset) in_frame = 1'b0;
        else if (e_rd) begin
          in_frame = 1'b1;
          p        = cyc;
          word     = r_data;
        end
      end
    end
  end

  int rb[NCFG];
  int db[NCFG];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [B-1:0] d);
    if (g_cfg[0].count < 8 && g_cfg[1].count < 8) begin
      wr = 1'b1;
      w_data = d;
      tick(1);
      wr = 1'b0;
    end else begin
      tick(1);
    end
  endtask

  task automatic snap();
    rb[0] = g_cfg[0].rd_n;   db[0] = g_cfg[0].done_n;
    rb[1] = g_cfg[1].rd_n;   db[1] = g_cfg[1].done_n;
  endtask

  task automatic expect_counts(input string tag, input int nrd, input int ndone, input bit chk_gap);
    check({tag, "_rd0"},    g_cfg[0].rd_n - rb[0], nrd);
    check({tag, "_done0"},  g_cfg[0].done_n - db[0], ndone);
    check({tag, "_empty0"}, g_cfg[0].empty, 1);
    check({tag, "_rd1"},    g_cfg[1].rd_n - rb[1], nrd);
    check({tag, "_done1"},  g_cfg[1].done_n - db[1], ndone);
    check({tag, "_empty1"}, g_cfg[1].empty, 1);
    if (chk_gap) begin
      check({tag, "_gap0"}, g_cfg[0].last_gap, flen(0) + 1);
      check({tag, "_gap1"}, g_cfg[1].last_gap, flen(1) + 1);
    end
  endtask

  initial begin
    int budget;
    n_checks = 0;
    n_pass   = 0;
    chk_en   = 1'b0;
    reset    = 1'b1;
    tx_en    = 1'b0;
    wr       = 1'b0;
    w_data   = '0;

    tick(1);
    chk_en = 1'b1;
    check("rst_tx0",   g_cfg[0].tx, 1);
    check("rst_busy0", g_cfg[0].tx_busy, 0);
    check("rst_done0", g_cfg[0].tx_done_tick, 0);
    check("rst_tx1",   g_cfg[1].tx, 1);
    check("rst_busy1", g_cfg[1].tx_busy, 0);

    // Single word; held off by reset first even with tx_en=1 and data present.
    snap();
    tx_en = 1'b1;
    push(8'hA5);
    tick(2);
    reset = 1'b0;
    tick(flen(0) + 10);
    expect_counts("single", 1, 1, 1'b0);

    // Back-to-back frames.
    tx_en = 1'b0;
    snap();
    push(8'h00); push(8'hFF); push(8'h3C);
    tx_en = 1'b1;
    tick(3 * (flen(0) + 1) + 10);
    expect_counts("b2b", 3, 3, 1'b1);

    // tx_en low holds a waiting word; raising it pops in the same cycle.
    tx_en = 1'b0;
    snap();
    push(8'h55);
    tick(500);
    check("hold_rd0", g_cfg[0].rd_n - rb[0], 0);
    check("hold_rd1", g_cfg[1].rd_n - rb[1], 0);
    tx_en = 1'b1;
    #1;
    check("en_rd0", g_cfg[0].rd, 1);
    check("en_rd1", g_cfg[1].rd, 1);
    tick(20);
    tx_en = 1'b0;
    tick(flen(0) + 10);
    expect_counts("en_drop", 1, 1, 1'b0);

    // Reset 50 cycles into a frame, then the next word goes out normally.
    snap();
    push(8'h81); push(8'h42);
    tx_en = 1'b1;
    tick(50);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(flen(0) + 10);
    expect_counts("midrst", 2, 1, 1'b0);

    // Fill all 8 entries and drain across the pointer wrap.
    tx_en = 1'b0;
    snap();
    for (int i = 0; i < 8; i++) push(B'($urandom));
    tx_en = 1'b1;
    tick(8 * (flen(0) + 1) + 10);
    expect_counts("wrap", 8, 8, 1'b1);

    // Random pushes and tx_en toggling.
    snap();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 15) == 0) push(B'($urandom));
      else tick(1);
    end
    tx_en = 1'b1;
    budget = 9 * (flen(0) + 1) + 50;
    while (budget > 0 && !(g_cfg[0].empty && g_cfg[1].empty &&
                           !g_cfg[0].tx_busy && !g_cfg[1].tx_busy)) begin
      tick(1);
      budget--;
    end
    check("drain_timeout", (budget > 0), 1);
    tick(2);
    check("rand_done0", g_cfg[0].done_n - db[0], g_cfg[0].rd_n - rb[0]);
    check("rand_done1", g_cfg[1].done_n - db[1], g_cfg[1].rd_n - rb[1]);
    check("rand_empty0", g_cfg[0].empty, 1);
    check("rand_empty1", g_cfg[1].empty, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
